// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
// Contents: FSM state encoding, register-zero constant and default widths/limits.
package hazard_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    localparam logic [4:0]  REG_ZERO    = 5'd0;
    localparam int unsigned CNT_W_DEF   = 16;
    localparam int unsigned TIMEOUT_DEF = 64;
    localparam int unsigned TO_W_DEF    = 7;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with enable and synchronous clear.
// Ports:
//   i_clk   clock
//   i_clr   synchronous clear (wins over enable)
//   i_en    count enable
//   o_count current count, holds at all-ones
module hazard_ctrl_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         i_clk,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipeline.
// Inserts one bubble on load-use hazards, freezes the pipeline while a data
// memory access is outstanding, flushes IF/ID on taken branches and jumps, and
// keeps saturating stall/flush counters plus a sticky memory-timeout flag.
// Ports:
//   clk_i, rst_i (sync, active-high)
//   ID_EX_MemRead_i, ID_EX_RegRt_i, IF_ID_RegRs_i, IF_ID_RegRt_i : hazard decode
//   branch_taken_i, jump_i : control-flow change resolved in ID
//   dmem_req_i, dmem_ack_i : data-memory handshake from MEM
//   PC_write_o, IF_ID_write_o, IF_ID_flush_o, ID_EX_bubble_o, pipe_freeze_o
//   mem_err_o, stall_cycles_o, flush_count_o : status and performance counters
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned TO_W    = TO_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ID_EX_MemRead_i,
    input  logic [4:0]       ID_EX_RegRt_i,
    input  logic [4:0]       IF_ID_RegRs_i,
    input  logic [4:0]       IF_ID_RegRt_i,
    input  logic             branch_taken_i,
    input  logic             jump_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ack_i,
    output logic             PC_write_o,
    output logic             IF_ID_write_o,
    output logic             IF_ID_flush_o,
    output logic             ID_EX_bubble_o,
    output logic             pipe_freeze_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_count_o
);

    state_e            r_state;
    state_e            w_state_d;
    logic [TO_W-1:0]   r_wait;
    logic [TO_W-1:0]   w_wait_d;
    logic              r_mem_err;
    logic              w_mem_err_d;

    logic              w_loaduse;
    logic              w_memstall;
    logic              w_frozen;
    logic              w_pc_write;
    logic              w_if_id_write;
    logic              w_flush;
    logic              w_bubble;
    logic [CNT_W-1:0]  w_stall_cnt;
    logic [CNT_W-1:0]  w_flush_cnt;

    assign w_loaduse  = ID_EX_MemRead_i && (ID_EX_RegRt_i != REG_ZERO) &&
                        ((ID_EX_RegRt_i == IF_ID_RegRs_i) ||
                         (ID_EX_RegRt_i == IF_ID_RegRt_i));
    assign w_memstall = dmem_req_i && !dmem_ack_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= RUN;
            r_wait    <= '0;
            r_mem_err <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_wait    <= w_wait_d;
            r_mem_err <= w_mem_err_d;
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_wait_d      = '0;
        w_mem_err_d   = r_mem_err;
        w_frozen      = 1'b0;
        w_pc_write    = 1'b1;
        w_if_id_write = 1'b1;
        w_flush       = 1'b0;
        w_bubble      = 1'b0;

        unique case (r_state)
            RUN: begin
                if (w_memstall) begin
                    w_frozen  = 1'b1;
                    w_state_d = MEM_WAIT;
                    w_wait_d  = TO_W'(1);
                end
            end
            MEM_WAIT: begin
                if (!dmem_ack_i) begin
                    w_frozen = 1'b1;
                    w_wait_d = (r_wait == '1) ? r_wait : r_wait + TO_W'(1);
                    if (r_wait == TO_W'(TIMEOUT)) begin
                        w_mem_err_d = 1'b1;
                    end
                end else begin
                    w_state_d = RUN;
                end
            end
            default: w_state_d = RUN;
        endcase

        // Freeze masks everything else; otherwise the ack cycle behaves like RUN.
        if (w_frozen) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
        end else if (w_loaduse) begin
            // Branch/jump ignored: the branch re-resolves after the bubble.
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_bubble      = 1'b1;
        end else if (branch_taken_i || jump_i) begin
            w_flush = 1'b1;
        end

        if (rst_i) begin
            w_frozen      = 1'b0;
            w_pc_write    = 1'b1;
            w_if_id_write = 1'b1;
            w_flush       = 1'b0;
            w_bubble      = 1'b0;
        end
    end

    hazard_ctrl_sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .i_clk   (clk_i),
        .i_clr   (rst_i),
        .i_en    (!w_pc_write),
        .o_count (w_stall_cnt)
    );

    hazard_ctrl_sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .i_clk   (clk_i),
        .i_clr   (rst_i),
        .i_en    (w_flush),
        .o_count (w_flush_cnt)
    );

    assign PC_write_o     = w_pc_write;
    assign IF_ID_write_o  = w_if_id_write;
    assign IF_ID_flush_o  = w_flush;
    assign ID_EX_bubble_o = w_bubble;
    assign pipe_freeze_o  = w_frozen;
    // Status reads as reset values for the whole cycle rst_i is high.
    assign mem_err_o      = r_mem_err && !rst_i;
    assign stall_cycles_o = rst_i ? '0 : w_stall_cnt;
    assign flush_count_o  = rst_i ? '0 : w_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned TO_W    = 3;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    localparam int WAIT_MAX = (1 << TO_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             memread;
    logic [4:0]       ex_rt;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             br;
    logic             jp;
    logic             req;
    logic             ack;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             bubble;
    logic             freeze;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .ID_EX_MemRead_i (memread),
        .ID_EX_RegRt_i   (ex_rt),
        .IF_ID_RegRs_i   (id_rs),
        .IF_ID_RegRt_i   (id_rt),
        .branch_taken_i  (br),
        .jump_i          (jp),
        .dmem_req_i      (req),
        .dmem_ack_i      (ack),
        .PC_write_o      (pc_write),
        .IF_ID_write_o   (if_id_write),
        .IF_ID_flush_o   (if_id_flush),
        .ID_EX_bubble_o  (bubble),
        .pipe_freeze_o   (freeze),
        .mem_err_o       (mem_err),
        .stall_cycles_o  (stall_cycles),
        .flush_count_o   (flush_count)
    );

    typedef struct {
        logic pc;
        logic ifid;
        logic flush;
        logic bub;
        logic frz;
        logic err;
        int   stall;
        int   flushes;
        int   cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    // Reference model state: "are we waiting on memory", how long, sticky error, counts.
    bit   m_waiting = 0;
    int   m_wlen    = 0;
    bit   m_err     = 0;
    int   m_stall   = 0;
    int   m_flush   = 0;

    task automatic chk(input string name, input int cyc, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Apply one cycle of inputs, predict that cycle's outputs, advance the model.
    task automatic step(input bit r, input bit mr, input bit [4:0] ert, input bit [4:0] rs,
                        input bit [4:0] rt, input bit b, input bit j, input bit rq,
                        input bit ak);
        exp_t e;
        bit   hazard;
        bit   frozen;
        @(posedge clk);
        #1;
        cycle++;
        rst = r; memread = mr; ex_rt = ert; id_rs = rs; id_rt = rt;
        br = b; jp = j; req = rq; ack = ak;

        hazard = mr && (ert != 0) && (ert == rs || ert == rt);
        frozen = m_waiting ? !ak : (rq && !ak);
        e.cyc = cycle;
        if (r) begin
            e = '{pc: 1, ifid: 1, flush: 0, bub: 0, frz: 0, err: 0, stall: 0, flushes: 0,
                  cyc: cycle};
            m_waiting = 0; m_wlen = 0; m_err = 0; m_stall = 0; m_flush = 0;
        end else begin
            e.frz   = frozen;
            e.bub   = !frozen && hazard;
            e.flush = !frozen && !hazard && (b || j);
            e.pc    = !(frozen || hazard);
            e.ifid  = e.pc;
            e.err   = m_err;
            e.stall = m_stall;
            e.flushes = m_flush;
            if (m_waiting && !ak && m_wlen == TIMEOUT) m_err = 1;
            if (!e.pc && m_stall < CNT_MAX) m_stall++;
            if (e.flush && m_flush < CNT_MAX) m_flush++;
            if (frozen) m_wlen = m_waiting ? ((m_wlen < WAIT_MAX) ? m_wlen + 1 : m_wlen) : 1;
            else m_wlen = 0;
            m_waiting = frozen;
        end
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: outputs are combinational, so every negedge presents one result.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pc_write",     e.cyc, 32'(pc_write),     32'(e.pc));
            chk("if_id_write",  e.cyc, 32'(if_id_write),  32'(e.ifid));
            chk("if_id_flush",  e.cyc, 32'(if_id_flush),  32'(e.flush));
            chk("id_ex_bubble", e.cyc, 32'(bubble),       32'(e.bub));
            chk("pipe_freeze",  e.cyc, 32'(freeze),       32'(e.frz));
            chk("mem_err",      e.cyc, 32'(mem_err),      32'(e.err));
            chk("stall_cycles", e.cyc, 32'(stall_cycles), 32'(e.stall));
            chk("flush_count",  e.cyc, 32'(flush_count),  32'(e.flushes));
        end
    end

    initial begin
        rst = 1; memread = 0; ex_rt = 0; id_rs = 0; id_rt = 0;
        br = 0; jp = 0; req = 0; ack = 0;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 2, 2, 0, 1, 0, 1, 0);
        idle(1);
        // Load-use on rs, then on rt, then $0 never stalls.
        step(0, 1, 2, 2, 5, 0, 0, 0, 0);
        idle(1);
        step(0, 1, 7, 3, 7, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        // Memory wait, ack after three frozen cycles; then same-cycle ack.
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1);
        // Priority: memstall beats load-use and branch; ack cycle bubbles; then flush.
        step(0, 1, 4, 4, 0, 1, 0, 1, 0);
        step(0, 1, 4, 4, 0, 1, 0, 1, 0);
        step(0, 1, 4, 4, 0, 1, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        // Timeout: ack withheld 10 cycles, flag sticky past ack until reset.
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0, 1, 1);
        idle(2);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        // Reset in the second wait cycle aborts to RUN.
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(1);
        // Flush saturation.
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, i[0], !i[0], 0, 0);

        for (int i = 0; i < 600; i++) begin
            bit r;
            r = ($urandom_range(0, 99) < 2);
            step(r, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 5) < 2);
        end
        idle(2);

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("queue_drained", cycle, 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
